tile_fetch_pipe: RTL and testbench
==================================

Name: tile_fetch_pipe

Overview:
- Upstream stage of the background sprite ROM.
- Converts the VGA raster position into an occupancy-grid lookup and a 30x30 sprite texel address, with no divide or multiply.
- Presents the tile state code and texel address to the background sprite ROM, aligned to that ROM's 1-cycle registered read.
- Emits a valid flag aligned to the ROM's 4-bit palette index output, for the downstream colour mapper.

Parameters:
BOARD_X0, 80, first screen column of the board
BOARD_Y0, 15, first screen row of the board
TILE, 30, tile edge in pixels; sprite ROM depth is TILE*TILE = 900
COLS, 15, tiles per board row
ROWS, 15, tiles per board column

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_en  in  1  draw_x/draw_y hold an active-video pixel this cycle, in raster order
draw_x  in  10  current pixel column
draw_y  in  10  current pixel row
grid_addr  out  8  occupancy-grid RAM read address = tile_row*COLS + tile_col
grid_state  in  4  occupancy code from grid RAM, valid 1 clk after grid_addr (registered RAM)
state  out  4  tile code to the sprite ROM; OCC_NONE (0) when off-board
read_address  out  10  texel address to the sprite ROM = off_y*TILE + off_x
pix_valid_out  out  1  high exactly when the sprite ROM data_Out belongs to an on-board pixel
on_board_out  out  1  aligned with pix_valid_out; pixel lies inside the board

Behaviour:
- Reset (async, active-high) clears all counters, pipeline registers and outputs to 0: grid_addr=0, state=0, read_address=0, pix_valid_out=0, on_board_out=0.
- Board region: BOARD_X0 <= draw_x < BOARD_X0+COLS*TILE and BOARD_Y0 <= draw_y < BOARD_Y0+ROWS*TILE.
- Horizontal counters off_x (0..TILE-1) and tile_col (0..COLS-1):
  - Loaded to 0 on any pix_en cycle with draw_x==BOARD_X0 in the board.
  - Otherwise they advance on every in-board pix_en.
  - off_x wraps at TILE-1, which also increments tile_col.
- Vertical counters off_y, tile_row, tex_row_base (=off_y*TILE) and cell_row_base (=tile_row*COLS):
  - Forced to 0 whenever pix_en and draw_y < BOARD_Y0.
  - Advance on the in-board pixel with draw_x==BOARD_X0+COLS*TILE-1 (last pixel of a board line).
  - off_y wrap: off_y=0 and tex_row_base=0, tile_row+1, cell_row_base+=COLS.
  - Otherwise: off_y+1, tex_row_base+=TILE.
- All address arithmetic is incremental. read_address never exceeds 899; grid_addr never exceeds COLS*ROWS-1 (224).
- Pipeline advances every clk; pix_en only gates the counters.
  - Stage A (edge after pixel N):
    - grid_addr <= cell_row_base + tile_col;
    - texA <= tex_row_base + off_x, using the pre-increment value for the current pixel (0 at the line-start load);
    - vA <= pix_en; bA <= pix_en & in_board.
  - Stage B (edge N+2):
    - read_address <= texA; vB <= vA; bB <= bA.
    - state is combinational: state = bB ? grid_state : 0. It therefore meets the ROM with the same alignment as read_address.
  - Stage C (edge N+3, when the ROM data_Out is valid): pix_valid_out <= vB; on_board_out <= bB.
- Off-board or non-pix_en cycles: grid_addr holds its last value, texA=0, state=0.
- Latency: pixel N to ROM data_Out = 3 clk, constant.
- Boundary cases:
  - Last board pixel (tile 14,14; off 29,29): grid_addr=224, read_address=899.
  - Next frame: counters re-zero above BOARD_Y0.
- Reset mid-frame: outputs are 0 immediately. Vertical alignment may be wrong until the next draw_y < BOARD_Y0 resync, and must be correct from the next frame's first board pixel.
- pix_en gaps (blanking): counter values are retained; no spurious advance.

Test Plan:
- Assert reset mid-stream -> all outputs 0 asynchronously. After release and a full frame, the first board pixel (80,15) gives grid_addr=0 and read_address=0, with pix_valid_out=1 and on_board_out=1 three clocks later.
- Pixel (80+31, 15+2), from a full raster sweep -> grid_addr=1, read_address=2*30+1=61. Grid RAM returns 9 -> state=9 on the clk where read_address=61.
- Pixel (80+449, 15+449) -> grid_addr=224, read_address=899. The next line yields pixels off-board: state=0, on_board_out=0, pix_valid_out=1.
- Pixel (79,100), just outside the left edge -> state=0 and on_board_out=0; pixel (80,100) -> off_x reloads to 0, read_address=(85%30)*30=750, grid_addr=2*15=30.
- pix_en low for 160 clk mid-line (blanking) -> counters unchanged, pix_valid_out low for 160 aligned clk, addresses continue correctly after the gap.
- Two consecutive frames with random grid contents -> every on-board pixel's (state, read_address) matches a reference model using x/30, x%30, with exact 3-clk alignment.

Source files
------------

// File: rtl/tile_fetch_pipe.sv
// tile_fetch_pipe: raster position to occupancy-grid address and 30x30 texel address,
// aligned to the background sprite ROM's registered read.
module tile_fetch_pipe #(
    parameter int BOARD_X0 = 80,
    parameter int BOARD_Y0 = 15,
    parameter int TILE     = 30,
    parameter int COLS     = 15,
    parameter int ROWS     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic [7:0] grid_addr,
    input  logic [3:0] grid_state,
    output logic [3:0] state,
    output logic [9:0] read_address,
    output logic       pix_valid_out,
    output logic       on_board_out
);
    localparam int XW = $clog2(TILE);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS);
    localparam logic [9:0] X0 = 10'(BOARD_X0);
    localparam logic [9:0] XE = 10'(BOARD_X0 + COLS * TILE);
    localparam logic [9:0] XL = 10'(BOARD_X0 + COLS * TILE - 1);
    localparam logic [9:0] Y0 = 10'(BOARD_Y0);
    localparam logic [9:0] YE = 10'(BOARD_Y0 + ROWS * TILE);
    localparam logic [XW-1:0] TL = XW'(TILE - 1);
    localparam logic [RW-1:0] RL = RW'(ROWS - 1);

    logic          in_board, adv, at_x0, wrap_x;
    logic [XW-1:0] off_x, off_y, cur_x;
    logic [CW-1:0] tile_col, cur_col;
    logic [RW-1:0] tile_row;
    logic [9:0]    tex_row_base, tex_a;
    logic [7:0]    cell_row_base;
    logic          v_a, b_a, v_b, b_b;

    assign in_board = draw_x >= X0 && draw_x < XE && draw_y >= Y0 && draw_y < YE;
    assign adv      = pix_en && in_board;
    assign at_x0    = draw_x == X0;
    // the line-start pixel uses zero for itself, so stale horizontal counts never leak in
    assign cur_x    = at_x0 ? '0 : off_x;
    assign cur_col  = at_x0 ? '0 : tile_col;
    assign wrap_x   = cur_x == TL;
    assign state    = b_b ? grid_state : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_x    <= '0;
            tile_col <= '0;
        end else if (adv) begin
            off_x    <= wrap_x ? '0 : cur_x + XW'(1);
            tile_col <= wrap_x ? cur_col + CW'(1) : cur_col;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_y         <= '0;
            tile_row      <= '0;
            tex_row_base  <= '0;
            cell_row_base <= '0;
        end else if (pix_en && draw_y < Y0) begin
            off_y         <= '0;
            tile_row      <= '0;
            tex_row_base  <= '0;
            cell_row_base <= '0;
        end else if (adv && draw_x == XL) begin
            off_y         <= off_y == TL ? '0 : off_y + XW'(1);
            tex_row_base  <= off_y == TL ? '0 : tex_row_base + 10'(TILE);
            tile_row      <= off_y != TL ? tile_row : tile_row == RL ? '0 : tile_row + RW'(1);
            cell_row_base <= off_y != TL ? cell_row_base : tile_row == RL ? '0 : cell_row_base + 8'(COLS);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grid_addr     <= '0;
            tex_a         <= '0;
            v_a           <= 1'b0;
            b_a           <= 1'b0;
            read_address  <= '0;
            v_b           <= 1'b0;
            b_b           <= 1'b0;
            pix_valid_out <= 1'b0;
            on_board_out  <= 1'b0;
        end else begin
            if (adv) grid_addr <= cell_row_base + 8'(cur_col);
            tex_a         <= adv ? tex_row_base + 10'(cur_x) : '0;
            v_a           <= pix_en;
            b_a           <= adv;
            read_address  <= tex_a;
            v_b           <= v_a;
            b_b           <= b_a;
            pix_valid_out <= v_b;
            on_board_out  <= b_b;
        end
    end
endmodule

// File: tb/tb_tile_fetch_pipe.sv
// tb_tile_fetch_pipe: directed scenarios plus reference-model frame sweeps for tile_fetch_pipe.
module tb_tile_fetch_pipe;
    logic       clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
    logic [9:0] draw_x = '0, draw_y = '0;
    logic [7:0] grid_addr;
    logic [3:0] grid_state = '0, state;
    logic [9:0] read_address;
    logic       pix_valid_out, on_board_out;
    logic [3:0] gmem [256];
    int         n_chk = 0, n_fail = 0;
    bit         h_en [4], h_onb [4], h_chk [4];
    int         h_ga [4], h_tex [4];

    tile_fetch_pipe dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .draw_x(draw_x), .draw_y(draw_y),
        .grid_addr(grid_addr), .grid_state(grid_state), .state(state),
        .read_address(read_address), .pix_valid_out(pix_valid_out), .on_board_out(on_board_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) grid_state <= gmem[grid_addr];

    // h_*[k] describes the pixel driven k cycles ago; returns at the following negedge
    task automatic drive(input int x, input int y, input bit en, input bit chk);
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            h_en[i] = h_en[i-1]; h_onb[i] = h_onb[i-1]; h_chk[i] = h_chk[i-1];
            h_ga[i] = h_ga[i-1]; h_tex[i] = h_tex[i-1];
        end
        h_en[0]  = en;
        h_chk[0] = chk;
        h_onb[0] = en && x >= 80 && x < 530 && y >= 15 && y < 465;
        h_ga[0]  = h_onb[0] ? ((y - 15) / 30) * 15 + (x - 80) / 30 : 0;
        h_tex[0] = h_onb[0] ? ((y - 15) % 30) * 30 + (x - 80) % 30 : 0;
        pix_en = en;
        draw_x = 10'(x);
        draw_y = 10'(y);
        @(negedge clk);
    endtask

    task automatic line(input int y, input bit full);
        if (y < 15 || y >= 465) drive(0, y, 1, 0);
        else if (full) for (int x = 80; x < 530; x++) drive(x, y, 1, 0);
        else drive(529, y, 1, 0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk++;
        if ({grid_addr, read_address, state, pix_valid_out, on_board_out} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_state got ga=%0d ra=%0d st=%0d v=%0d b=%0d want all 0",
                     grid_addr, read_address, state, pix_valid_out, on_board_out);
        end
        reset = 1'b0;
        for (int y = 0; y < 20; y++) line(y, 0);
        for (int x = 80; x < 150; x++) drive(x, 20, 1, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_chk++;
        if ({grid_addr, read_address, state, pix_valid_out, on_board_out} !== 24'd0) begin
            n_fail++;
            $display("FAIL async_reset got ga=%0d ra=%0d st=%0d v=%0d b=%0d want all 0",
                     grid_addr, read_address, state, pix_valid_out, on_board_out);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int y = 0; y < 15; y++) line(y, 0);
        drive(80, 15, 1, 0);
        drive(81, 15, 1, 0);
        n_chk++;
        if (grid_addr !== 8'd0) begin
            n_fail++; $display("FAIL first_grid_addr got %0d want 0", grid_addr);
        end
        drive(82, 15, 1, 0);
        n_chk++;
        if (read_address !== 10'd0 || state !== gmem[0]) begin
            n_fail++; $display("FAIL first_read got ra=%0d st=%0d want 0/%0d", read_address, state, gmem[0]);
        end
        drive(83, 15, 1, 0);
        n_chk++;
        if (pix_valid_out !== 1'b1 || on_board_out !== 1'b1) begin
            n_fail++; $display("FAIL first_valid got v=%0d b=%0d want 1/1", pix_valid_out, on_board_out);
        end
    endtask

    task automatic test_sweep;
        for (int y = 0; y < 17; y++) line(y, 0);
        for (int x = 80; x < 112; x++) drive(x, 17, 1, 0);
        drive(112, 17, 1, 0);
        n_chk++;
        if (grid_addr !== 8'd1) begin
            n_fail++; $display("FAIL sweep_grid_addr got %0d want 1", grid_addr);
        end
        drive(113, 17, 1, 0);
        n_chk++;
        if (read_address !== 10'd61 || state !== 4'd9) begin
            n_fail++; $display("FAIL sweep_read got ra=%0d st=%0d want 61/9", read_address, state);
        end
        drive(114, 17, 1, 0);
        n_chk++;
        if (pix_valid_out !== 1'b1 || on_board_out !== 1'b1) begin
            n_fail++; $display("FAIL sweep_valid got v=%0d b=%0d want 1/1", pix_valid_out, on_board_out);
        end
    endtask

    task automatic test_edge;
        for (int y = 0; y < 100; y++) line(y, 0);
        drive(79, 100, 1, 0);
        drive(80, 100, 1, 0);
        drive(81, 100, 1, 0);
        n_chk++;
        if (grid_addr !== 8'd30 || read_address !== 10'd0 || state !== 4'd0) begin
            n_fail++;
            $display("FAIL edge_left got ga=%0d ra=%0d st=%0d want 30/0/0", grid_addr, read_address, state);
        end
        drive(82, 100, 1, 0);
        n_chk++;
        if (read_address !== 10'd750 || state !== gmem[30]) begin
            n_fail++; $display("FAIL edge_reload got ra=%0d st=%0d want 750/%0d", read_address, state, gmem[30]);
        end
        n_chk++;
        if (pix_valid_out !== 1'b1 || on_board_out !== 1'b0) begin
            n_fail++; $display("FAIL edge_offboard got v=%0d b=%0d want 1/0", pix_valid_out, on_board_out);
        end
    endtask

    task automatic test_gap;
        logic [3:0] exp_s;
        for (int y = 0; y < 40; y++) line(y, 0);
        for (int k = 0; k < 221; k++) begin
            if (k < 21) drive(80 + k, 40, 1, 1);
            else if (k < 181) drive(101, 40, 0, 1);
            else drive(101 + k - 181, 40, 1, 1);
            exp_s = h_onb[2] ? gmem[h_ga[2]] : 4'd0;
            if (h_chk[1] && h_onb[1]) begin
                n_chk++;
                if (grid_addr !== 8'(h_ga[1])) begin
                    n_fail++; $display("FAIL gap_grid_addr k=%0d got %0d want %0d", k, grid_addr, h_ga[1]);
                end
            end
            if (h_chk[2]) begin
                n_chk++;
                if (read_address !== 10'(h_tex[2]) || state !== exp_s) begin
                    n_fail++;
                    $display("FAIL gap_read k=%0d got ra=%0d st=%0d want %0d/%0d", k, read_address, state, h_tex[2], exp_s);
                end
            end
            if (h_chk[3]) begin
                n_chk++;
                if (pix_valid_out !== h_en[3] || on_board_out !== h_onb[3]) begin
                    n_fail++;
                    $display("FAIL gap_valid k=%0d got v=%0d b=%0d want %0d/%0d", k, pix_valid_out, on_board_out, h_en[3], h_onb[3]);
                end
            end
        end
    endtask

    task automatic test_last;
        for (int y = 0; y < 464; y++) line(y, 0);
        line(464, 1);
        drive(80, 465, 1, 0);
        n_chk++;
        if (grid_addr !== 8'd224) begin
            n_fail++; $display("FAIL last_grid_addr got %0d want 224", grid_addr);
        end
        drive(81, 465, 1, 0);
        n_chk++;
        if (read_address !== 10'd899 || state !== 4'd5) begin
            n_fail++; $display("FAIL last_read got ra=%0d st=%0d want 899/5", read_address, state);
        end
        drive(82, 465, 1, 0);
        n_chk++;
        if (pix_valid_out !== 1'b1 || on_board_out !== 1'b1) begin
            n_fail++; $display("FAIL last_valid got v=%0d b=%0d want 1/1", pix_valid_out, on_board_out);
        end
        drive(83, 465, 1, 0);
        n_chk++;
        if (read_address !== 10'd0 || state !== 4'd0) begin
            n_fail++; $display("FAIL below_read got ra=%0d st=%0d want 0/0", read_address, state);
        end
        drive(84, 465, 1, 0);
        n_chk++;
        if (pix_valid_out !== 1'b1 || on_board_out !== 1'b0) begin
            n_fail++; $display("FAIL below_valid got v=%0d b=%0d want 1/0", pix_valid_out, on_board_out);
        end
    endtask

    task automatic test_frames;
        logic [3:0] exp_s;
        bit full;
        int n;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 256; i++) gmem[i] = 4'($urandom_range(15));
            for (int y = 0; y < 480; y++) begin
                full = y == 15 || y == 464 || (y % 41) == f * 7 + 3;
                n = (y >= 15 && y < 465 && full) ? 455 : 1;
                for (int k = 0; k < n; k++) begin
                    if (y < 15 || y >= 465) drive(0, y, 1, 1);
                    else if (full) drive(78 + k, y, k < 454, 1);
                    else drive(529, y, 1, 0);
                    exp_s = h_onb[2] ? gmem[h_ga[2]] : 4'd0;
                    if (h_chk[1] && h_onb[1]) begin
                        n_chk++;
                        if (grid_addr !== 8'(h_ga[1])) begin
                            n_fail++; $display("FAIL frame_grid_addr y=%0d k=%0d got %0d want %0d", y, k, grid_addr, h_ga[1]);
                        end
                    end
                    if (h_chk[2]) begin
                        n_chk++;
                        if (read_address !== 10'(h_tex[2]) || state !== exp_s) begin
                            n_fail++;
                            $display("FAIL frame_read y=%0d k=%0d got ra=%0d st=%0d want %0d/%0d", y, k, read_address, state, h_tex[2], exp_s);
                        end
                    end
                    if (h_chk[3]) begin
                        n_chk++;
                        if (pix_valid_out !== h_en[3] || on_board_out !== h_onb[3]) begin
                            n_fail++;
                            $display("FAIL frame_valid y=%0d k=%0d got v=%0d b=%0d want %0d/%0d", y, k, pix_valid_out, on_board_out, h_en[3], h_onb[3]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) gmem[i] = 4'((i * 7 + 3) % 16);
        gmem[1]   = 4'd9;
        gmem[30]  = 4'd12;
        gmem[224] = 4'd5;
        test_reset;
        test_sweep;
        test_edge;
        test_gap;
        test_last;
        test_frames;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
